// File: rtl/morph_pkg.sv
// Shared types and constants for the 3x3 morphology filter.
package morph_pkg;

  typedef enum logic {
    MORPH_DILATE = 1'b0,
    MORPH_ERODE  = 1'b1
  } morph_mode_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_FLUSH
  } state_e;

  localparam int WIN_TAPS = 9;

  // Identity for min: all ones at width w.
  function automatic logic [63:0] ident_min(input int w);
    return (64'd1 << w) - 64'd1;
  endfunction

  // Identity for max: zero, expressed against the same width mask.
  function automatic logic [63:0] ident_max(input int w);
    return ident_min(w) & ~ident_min(w);
  endfunction

endpackage

// File: rtl/morph_line_buffer.sv
// Two-row line buffer: one read and one write per strobe at the same column.
// row1 returns the column of row r-1, row2 the column of row r-2.
module morph_line_buffer #(
  parameter int IMG_W  = 320,
  parameter int DATA_W = 8,
  parameter int AW     = $clog2(IMG_W)
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [AW-1:0]     addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] row1,
  output logic [DATA_W-1:0] row2
);

  logic [DATA_W-1:0] mem1 [IMG_W];
  logic [DATA_W-1:0] mem2 [IMG_W];

  assign row1 = mem1[addr];
  assign row2 = mem2[addr];

  // No reset: stale rows are masked by the window border logic.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem1[addr] <= wdata;
      mem2[addr] <= mem1[addr];
    end
  end

endmodule

// File: rtl/morph_filter_3x3.sv
// Streaming 3x3 grey-scale dilate/erode with border policy, framing flags and end-of-frame flush.
// Optional MORPH_SE_MASK_EN adds cfg_se_mask, a per-frame structuring-element tap mask.
module morph_filter_3x3
  import morph_pkg::*;
#(
  parameter int                IMG_W      = 320,
  parameter int                IMG_H      = 464,
  parameter int                DATA_W     = 8,
  parameter logic [DATA_W-1:0] BORDER_VAL = '0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cfg_mode,
  input  logic                cfg_border,
`ifdef MORPH_SE_MASK_EN
  input  logic [WIN_TAPS-1:0] cfg_se_mask,
`endif
  input  logic                in_valid,
  output logic                in_ready,
  input  logic                in_sof,
  input  logic [DATA_W-1:0]   in_data,
  output logic                out_valid,
  output logic [DATA_W-1:0]   out_data,
  output logic                out_sof,
  output logic                out_eol,
  output logic                out_eof
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H + 2);
  localparam logic [DATA_W-1:0] ID_MAX = DATA_W'(ident_max(DATA_W));
  localparam logic [DATA_W-1:0] ID_MIN = DATA_W'(ident_min(DATA_W));

  state_e              state, state_nxt;
  logic [CW-1:0]       col_q, col_nxt, pos_c;
  logic [RW-1:0]       row_q, row_nxt, pos_r;
  logic                sof_acc, acc, stb, abort;
  logic                wrap, emit, at_top, at_bot, at_left, at_right;
  morph_mode_e         mode_q, s1_mode;
  logic                border_q, s1_border;
  logic [WIN_TAPS-1:0] mask_q, s1_mask;
  logic                s1_top, s1_bot, s1_left, s1_right;
  logic [DATA_W-1:0]   lb_r1, lb_r2, res;
  logic [2:0][2:0][DATA_W-1:0] win_q;  // [row][col], row 0 = oldest line
  logic [2:1]          vld_pipe;

  assign in_ready = (state != ST_FLUSH);
  assign sof_acc  = in_valid && in_ready && in_sof;
  assign acc      = sof_acc || (in_valid && in_ready && state == ST_RUN);
  assign stb      = acc || (state == ST_FLUSH);
  assign abort    = sof_acc && (state != ST_IDLE);
  assign pos_c    = sof_acc ? '0 : col_q;
  assign pos_r    = sof_acc ? '0 : row_q;

  always_comb begin
    state_nxt = state;
    col_nxt   = col_q;
    row_nxt   = row_q;
    if (stb) begin
      if (pos_c == CW'(IMG_W - 1)) begin
        col_nxt = '0;
        row_nxt = pos_r + RW'(1);
      end else begin
        col_nxt = pos_c + CW'(1);
        row_nxt = pos_r;
      end
    end
    case (state)
      ST_IDLE:  if (sof_acc) state_nxt = ST_RUN;
      ST_RUN:   if (acc && pos_r == RW'(IMG_H - 1) && pos_c == CW'(IMG_W - 1)) state_nxt = ST_FLUSH;
      ST_FLUSH: if (row_q == RW'(IMG_H + 1)) begin
                  state_nxt = ST_IDLE;
                  col_nxt   = '0;
                  row_nxt   = '0;
                end
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      col_q <= '0;
      row_q <= '0;
    end else begin
      state <= state_nxt;
      col_q <= col_nxt;
      row_q <= row_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q   <= MORPH_DILATE;
      border_q <= 1'b0;
    end else if (sof_acc) begin
      mode_q   <= morph_mode_e'(cfg_mode);
      border_q <= cfg_border;
    end
  end

`ifdef MORPH_SE_MASK_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          mask_q <= '1;
    else if (sof_acc) mask_q <= cfg_se_mask;
  end
`else
  assign mask_q = '1;
`endif

  // A strobe at input (r+1,c+1) completes output (r,c); column 0 completes the previous row's last pixel.
  assign wrap     = (pos_c == '0);
  assign emit     = (pos_r >= RW'(2)) || (pos_r == RW'(1) && !wrap);
  assign at_top   = wrap ? (pos_r == RW'(2)) : (pos_r == RW'(1));
  assign at_bot   = wrap ? (pos_r == RW'(IMG_H + 1)) : (pos_r == RW'(IMG_H));
  assign at_left  = (pos_c == CW'(1));
  assign at_right = wrap;

  morph_line_buffer #(.IMG_W(IMG_W), .DATA_W(DATA_W), .AW(CW)) u_lb (
    .clk   (clk),
    .wr_en (stb),
    .addr  (pos_c),
    .wdata (in_data),
    .row1  (lb_r1),
    .row2  (lb_r2)
  );

  always_ff @(posedge clk) begin
    if (stb) begin
      for (int r = 0; r < 3; r++) begin
        win_q[r][0] <= win_q[r][1];
        win_q[r][1] <= win_q[r][2];
      end
      win_q[0][2] <= lb_r2;
      win_q[1][2] <= lb_r1;
      win_q[2][2] <= in_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_top    <= 1'b0;
      s1_bot    <= 1'b0;
      s1_left   <= 1'b0;
      s1_right  <= 1'b0;
      s1_mode   <= MORPH_DILATE;
      s1_border <= 1'b0;
      s1_mask   <= '1;
    end else if (stb) begin
      s1_top    <= at_top;
      s1_bot    <= at_bot;
      s1_left   <= at_left;
      s1_right  <= at_right;
      s1_mode   <= mode_q;
      s1_border <= border_q;
      s1_mask   <= mask_q;
    end
  end

  always_comb begin
    logic [DATA_W-1:0] id, tap;
    logic              oob;
    id  = (s1_mode == MORPH_ERODE) ? ID_MIN : ID_MAX;
    res = id;
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 3; c++) begin
        oob = (r == 0 && s1_top) || (r == 2 && s1_bot) || (c == 0 && s1_left) || (c == 2 && s1_right);
        tap = win_q[r][c];
        if (!s1_mask[r*3+c]) tap = id;
        else if (oob)        tap = s1_border ? BORDER_VAL : id;
        if (s1_mode == MORPH_ERODE) res = (tap < res) ? tap : res;
        else                        res = (tap > res) ? tap : res;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_pipe <= '0;
      out_data <= '0;
      out_sof  <= 1'b0;
      out_eol  <= 1'b0;
      out_eof  <= 1'b0;
    end else begin
      vld_pipe[1] <= stb && emit;
      vld_pipe[2] <= vld_pipe[1] && !abort;
      if (vld_pipe[1]) out_data <= res;
      out_sof <= vld_pipe[1] && !abort && s1_top && s1_left;
      out_eol <= vld_pipe[1] && !abort && s1_right;
      out_eof <= vld_pipe[1] && !abort && s1_bot && s1_right;
    end
  end

  assign out_valid = vld_pipe[2];

endmodule

// File: tb/tb_morph_filter_3x3.sv
// Scoreboard bench for morph_filter_3x3 on a 4x3 image: a direct 3x3 reference model
// fills the expected queue as frames are driven; outputs are popped and checked at negedge.
module tb_morph_filter_3x3;
  localparam int W = 4;
  localparam int H = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic       cfg_mode, cfg_border;
  logic       in_valid, in_ready, in_sof;
  logic [7:0] in_data;
  logic       out_valid, out_sof, out_eol, out_eof;
  logic [7:0] out_data;
`ifdef MORPH_SE_MASK_EN
  logic [8:0] cfg_se_mask;
`endif

  logic [10:0] q[$];
  logic [7:0]  img [H][W];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  morph_filter_3x3 #(.IMG_W(W), .IMG_H(H), .DATA_W(8), .BORDER_VAL(8'd0)) dut (
    .clk        (clk),
    .rst        (rst),
    .cfg_mode   (cfg_mode),
    .cfg_border (cfg_border),
`ifdef MORPH_SE_MASK_EN
    .cfg_se_mask(cfg_se_mask),
`endif
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_sof     (in_sof),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_sof    (out_sof),
    .out_eol    (out_eol),
    .out_eof    (out_eof)
  );

  function automatic logic [7:0] exp_pix(input int r, input int c, input bit mode,
                                         input bit border, input logic [8:0] mask);
    logic [7:0] id, a, t;
    int rr, cc;
    id = mode ? 8'hFF : 8'h00;
    a  = id;
    for (int dr = 0; dr < 3; dr++) begin
      for (int dc = 0; dc < 3; dc++) begin
        rr = r + dr - 1;
        cc = c + dc - 1;
        if (!mask[dr*3+dc])                         t = id;
        else if (rr < 0 || rr >= H || cc < 0 || cc >= W) t = border ? 8'd0 : id;
        else                                        t = img[rr][cc];
        if (mode) a = (t < a) ? t : a;
        else      a = (t > a) ? t : a;
      end
    end
    return a;
  endfunction

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic check_out();
    logic [10:0] obs, exp;
    if (out_valid === 1'b1) begin
      obs = {out_data, out_sof, out_eol, out_eof};
      exp = (q.size() > 0) ? q.pop_front() : 11'bx;
      checks++;
      assert (obs === exp) else begin
        errors++;
        $error("FAIL out_pixel observed=%h expected=%h (data,sof,eol,eof)", obs, exp);
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
    check_out();
  endtask

  task automatic wait_ready();
    int t = 0;
    while (in_ready !== 1'b1 && t < 50) begin
      step();
      t++;
    end
    check_bit("wait_ready", in_ready, 1'b1);
  endtask

  task automatic send_frame(input bit mode, input bit border, input logic [8:0] mask,
                            input bit gaps, input int npix, input bit push);
    wait_ready();
    cfg_mode   = mode;
    cfg_border = border;
`ifdef MORPH_SE_MASK_EN
    cfg_se_mask = mask;
`endif
    if (push)
      for (int r = 0; r < H; r++)
        for (int c = 0; c < W; c++)
          q.push_back({exp_pix(r, c, mode, border, mask), r == 0 && c == 0, c == W - 1,
                       r == H - 1 && c == W - 1});
    for (int i = 0; i < npix; i++) begin
      in_valid = 1'b1;
      in_sof   = (i == 0);
      in_data  = img[i / W][i % W];
      step();
      if (gaps) begin
        in_valid = 1'b0;
        in_sof   = 1'b0;
        step();
      end
    end
    in_valid = 1'b0;
    in_sof   = 1'b0;
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 12; i++) step();
    checks++;
    assert (q.size() == 0) else begin
      errors++;
      $error("FAIL %s pending=%0d expected=0", tag, q.size());
    end
  endtask

  task automatic fill(input logic [7:0] v);
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) img[r][c] = v;
  endtask

  task automatic fill_rand();
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) img[r][c] = 8'($urandom_range(0, 255));
  endtask

  initial begin
    int lo;
    rst = 1'b1; cfg_mode = 1'b0; cfg_border = 1'b0;
    in_valid = 1'b0; in_sof = 1'b0; in_data = 8'd0;
`ifdef MORPH_SE_MASK_EN
    cfg_se_mask = 9'h1FF;
`endif
    step();
    step();
    check_bit("rst_out_valid", out_valid, 1'b0);
    check_bit("rst_in_ready", in_ready, 1'b1);
    check_bit("rst_out_sof", out_sof, 1'b0);
    check_bit("rst_out_eof", out_eof, 1'b0);
    checks++;
    assert (out_data === 8'd0) else begin
      errors++;
      $error("FAIL rst_out_data observed=%h expected=00", out_data);
    end
    rst = 1'b0;
    step();

    // Pixels without SOF while idle are dropped.
    in_valid = 1'b1; in_data = 8'd99;
    for (int i = 0; i < 3; i++) step();
    in_valid = 1'b0;
    drain("idle_drop");

    fill(8'd0); img[1][1] = 8'd200;
    send_frame(1'b0, 1'b0, 9'h1FF, 1'b0, W * H, 1'b1);

    fill(8'd255); img[0][3] = 8'd10;
    send_frame(1'b1, 1'b0, 9'h1FF, 1'b0, W * H, 1'b1);

    fill(8'd255);
    send_frame(1'b1, 1'b1, 9'h1FF, 1'b0, W * H, 1'b1);
    drain("erode_border");

    // Alternating valid; flush holds in_ready low for IMG_W+1 cycles.
    fill_rand();
    send_frame(1'b0, 1'b0, 9'h1FF, 1'b1, W * H - 1, 1'b1);
    in_valid = 1'b1; in_data = img[H-1][W-1];
    step();
    in_valid = 1'b0;
    lo = 0;
    while (in_ready === 1'b0 && lo < 50) begin
      lo++;
      step();
    end
    checks++;
    assert (lo == W + 1) else begin
      errors++;
      $error("FAIL flush_ready_low observed=%0d expected=%0d", lo, W + 1);
    end
    drain("gapped");

    // Abort: SOF re-asserted at pixel 6; only frame 2 may produce output.
    fill_rand();
    send_frame(1'b0, 1'b0, 9'h1FF, 1'b0, 6, 1'b0);
    fill_rand();
    send_frame(1'b1, 1'b0, 9'h1FF, 1'b0, W * H, 1'b1);
    drain("abort");

    // Reset during FLUSH, then a dim frame after a bright one.
    fill(8'd255);
    send_frame(1'b0, 1'b0, 9'h1FF, 1'b0, W * H, 1'b1);
    step();
    rst = 1'b1;
    step();
    check_bit("midflush_rst_out_valid", out_valid, 1'b0);
    check_bit("midflush_rst_in_ready", in_ready, 1'b1);
    q.delete();
    rst = 1'b0;
    step();
    fill(8'd0); img[2][3] = 8'd50;
    send_frame(1'b0, 1'b0, 9'h1FF, 1'b0, W * H, 1'b1);
    drain("after_rst");

`ifdef MORPH_SE_MASK_EN
    fill_rand();
    send_frame(1'b0, 1'b0, 9'b000_010_000, 1'b0, W * H, 1'b1);
    drain("se_mask_centre");
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
